// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-synchronous display loads.
// Optional leading-zero blanking is compiled in with `define SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_val,
   output logic                    wr_rdy,
   input  logic [4*NUM_DIGITS-1:0] wr_data,
   output logic [3:0]              dec_in,
   input  logic [6:0]              dec_seg,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(SCAN_DIV - 1);
   localparam logic [6:0]            SEG_OFF  = 7'h7F;
   localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

   typedef enum logic {
      BLANK,
      DRIVE
   } state_t;

   state_t                  state;
   logic [IDX_W-1:0]        idx;
   logic [CNT_W-1:0]        cnt;
   logic [4*NUM_DIGITS-1:0] shown;
   logic [4*NUM_DIGITS-1:0] pending;
   logic                    pend_v;
   logic                    drive_lit;

   assign dec_in     = shown[{idx, 2'b00} +: 4];
   assign wr_rdy     = !pend_v;
   assign frame_done = (state == DRIVE) && (cnt == LAST_CNT) && (idx == LAST_IDX);

`ifdef SEVEN_SEG_LZ_BLANK_EN
   logic [IDX_W-1:0] msd;

   // NOTE: combinational blocks use blocking assignments and assign a default
   // first, so every path writes msd and no latch is inferred.
   always_comb begin
      msd = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (shown[4*i +: 4] != 4'h0) msd = IDX_W'(i);
      end
   end

   assign drive_lit = (idx <= msd);
`else
   assign drive_lit = 1'b1;
`endif

   // Outputs are loaded one edge ahead so that an/seg are lit exactly while
   // the FSM sits in DRIVE and dark for the single BLANK cycle.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= BLANK;
         idx     <= '0;
         cnt     <= '0;
         shown   <= '0;
         pending <= '0;
         pend_v  <= 1'b0;
         an      <= '0;
         seg     <= SEG_OFF;
      end else begin
         if (wr_val && wr_rdy) begin
            pending <= wr_data;
            pend_v  <= 1'b1;
         end else if (frame_done && pend_v) begin
            shown  <= pending;
            pend_v <= 1'b0;
         end

         case (state)
            BLANK: begin
               state <= DRIVE;
               cnt   <= '0;
               an    <= drive_lit ? (AN_ONE << idx) : '0;
               seg   <= drive_lit ? dec_seg : SEG_OFF;
            end
            DRIVE: begin
               if (cnt == LAST_CNT) begin
                  state <= BLANK;
                  idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                  an    <= '0;
                  seg   <= SEG_OFF;
               end else begin
                  cnt <= cnt + 1'b1;
                  an  <= drive_lit ? (AN_ONE << idx) : '0;
                  seg <= drive_lit ? dec_seg : SEG_OFF;
               end
            end
            default: state <= BLANK;
         endcase
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: frame-position model checked every cycle,
// plus directed writes with hand-computed expectations.
module tb_seven_seg_scan_ctrl;

   localparam int ND    = 4;
   localparam int SD    = 4;
   localparam int SLOT  = SD + 1;
   localparam int FRAME = ND * SLOT;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_val = 1'b0;
   logic [15:0]   wr_data = 16'h0;
   logic          wr_rdy;
   logic [3:0]    dec_in;
   logic [6:0]    dec_seg;
   logic [6:0]    seg;
   logic [ND-1:0] an;
   logic          frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Shared decoder: active-low segments gfedcba.
   function automatic logic [6:0] seg_of(input logic [3:0] v);
      logic [6:0] hi;
      case (v)
         4'h0: hi = 7'h3F; 4'h1: hi = 7'h06; 4'h2: hi = 7'h5B; 4'h3: hi = 7'h4F;
         4'h4: hi = 7'h66; 4'h5: hi = 7'h6D; 4'h6: hi = 7'h7D; 4'h7: hi = 7'h07;
         4'h8: hi = 7'h7F; 4'h9: hi = 7'h6F; 4'hA: hi = 7'h77; 4'hB: hi = 7'h7C;
         4'hC: hi = 7'h39; 4'hD: hi = 7'h5E; 4'hE: hi = 7'h79; default: hi = 7'h71;
      endcase
      return ~hi;
   endfunction

   assign dec_seg = seg_of(dec_in);

   seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
      .clk(clk), .rst(rst), .wr_val(wr_val), .wr_rdy(wr_rdy), .wr_data(wr_data),
      .dec_in(dec_in), .dec_seg(dec_seg), .seg(seg), .an(an), .frame_done(frame_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: t counts cycles since reset; display content follows frame-end loads.
   int          t = -1;
   logic [15:0] m_shown = 16'h0;
   logic [15:0] m_pend  = 16'h0;
   logic        m_pv    = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         t       <= 0;
         m_shown <= 16'h0;
         m_pend  <= 16'h0;
         m_pv    <= 1'b0;
      end else if (t >= 0) begin
         if (wr_val && !m_pv) begin
            m_pend <= wr_data;
            m_pv   <= 1'b1;
         end else if ((t % FRAME) == FRAME - 1 && m_pv) begin
            m_shown <= m_pend;
            m_pv    <= 1'b0;
         end
         t <= t + 1;
      end
   end

   function automatic bit digit_lit(input int d, input logic [15:0] shown);
`ifdef SEVEN_SEG_LZ_BLANK_EN
      int msd = 0;
      for (int i = 1; i < ND; i++) if (shown[4*i +: 4] != 4'h0) msd = i;
      return d <= msd;
`else
      return 1'b1;
`endif
   endfunction

   int         pos, dgt, slot;
   logic [3:0] val;
   bit         lit;

   always @(negedge clk) begin
      if (t >= 0) begin
         pos  = t % FRAME;
         dgt  = pos / SLOT;
         slot = pos % SLOT;
         val  = m_shown[4*dgt +: 4];
         lit  = (slot != 0) && digit_lit(dgt, m_shown);
         check("model dec_in", 32'(dec_in), 32'(val));
         check("model an", 32'(an), lit ? (32'd1 << dgt) : 32'd0);
         check("model seg", 32'(seg), 32'(lit ? seg_of(val) : 7'h7F));
         check("model wr_rdy", 32'(wr_rdy), 32'(!m_pv));
         check("model frame_done", 32'(frame_done), 32'(pos == FRAME - 1));
      end
   end

   task automatic wait_t(input int k);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (t != k && n < 400);
      if (t != k) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_t timeout: t=%0d expected %0d", t, k);
      end
   endtask

   initial begin
      logic [ND-1:0] seen;
      logic [ND-1:0] exp_seen;
      logic [ND-1:0] exp_an51;
`ifdef SEVEN_SEG_LZ_BLANK_EN
      exp_seen = 4'b0011;
      exp_an51 = 4'b0000;
`else
      exp_seen = 4'b1111;
      exp_an51 = 4'b0100;
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset an", 32'(an), 32'h0);
      check("reset seg", 32'(seg), 32'h7F);
      check("reset wr_rdy", 32'(wr_rdy), 32'h1);
      check("reset frame_done", 32'(frame_done), 32'h0);
      wait_t(1);  check("frame0 an d0", 32'(an), 32'h1);
      wait_t(5);  check("frame0 gap", 32'(an), 32'h0);
      wait_t(6);  check("frame0 an d1", 32'(an), 32'h2);

      // Mid-frame write becomes visible from the next frame.
      wait_t(8);  wr_val = 1'b1; wr_data = 16'h1234;
      wait_t(9);  wr_val = 1'b0; check("1234 wr_rdy low", 32'(wr_rdy), 32'h0);
      wait_t(19); check("1234 still busy", 32'(wr_rdy), 32'h0);
      check("frame_done t19", 32'(frame_done), 32'h1);
      wait_t(20); check("1234 wr_rdy back", 32'(wr_rdy), 32'h1);
      wait_t(21); check("1234 dec_in d0", 32'(dec_in), 32'h4);
      check("1234 seg d0", 32'(seg), 32'h19);

      // ABCD held while busy is only captured once wr_rdy returns.
      wait_t(22); wr_val = 1'b1; wr_data = 16'h9876;
      wait_t(23); wr_data = 16'hABCD;
      wait_t(40); check("abcd rdy at frame", 32'(wr_rdy), 32'h1);
      wait_t(41); wr_val = 1'b0;
      check("abcd captured", 32'(wr_rdy), 32'h0);
      check("9876 dec_in d0", 32'(dec_in), 32'h6);
      wait_t(61); check("abcd dec_in d0", 32'(dec_in), 32'hD);

      // Write on the frame_done cycle lands one frame later.
      wait_t(79); check("frame_done t79", 32'(frame_done), 32'h1);
      wr_val = 1'b1; wr_data = 16'h5555;
      wait_t(80); wr_val = 1'b0;
      wait_t(81); check("5555 deferred", 32'(dec_in), 32'hD);
      wait_t(101); check("5555 shown", 32'(dec_in), 32'h5);

      // Reset during DRIVE of digit 2 discards the pending value.
      wait_t(102); wr_val = 1'b1; wr_data = 16'h7777;
      wait_t(103); wr_val = 1'b0; check("7777 pending", 32'(wr_rdy), 32'h0);
      wait_t(112); check("drive d2", 32'(an), 32'h4);
      rst = 1'b1;
      wait_t(0);  rst = 1'b0;
      check("midscan rst an", 32'(an), 32'h0);
      check("midscan rst seg", 32'(seg), 32'h7F);
      check("midscan rst wr_rdy", 32'(wr_rdy), 32'h1);
      wait_t(21); check("pending lost", 32'(dec_in), 32'h0);

      // 0042: digit enables seen over one full frame.
      wait_t(25); wr_val = 1'b1; wr_data = 16'h0042;
      wait_t(26); wr_val = 1'b0;
      seen = '0;
      for (int k = 40; k < 60; k++) begin
         wait_t(k);
         seen |= an;
         if (k == 51) check("0042 an d2", 32'(an), 32'(exp_an51));
      end
      check("0042 an codes", 32'(seen), 32'(exp_seen));
      wait_t(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
